// File: rtl/am_lock_detector.sv
// Alignment-marker lock detector: finds AM_PATTERN in the received nibble stream,
// verifies its period, declares lock and tracks loss of lock. Optional macro: AM_ERR_TOL_EN.
module am_lock_detector #(
  parameter logic [119:0] AM_PATTERN    = 120'hC16821F43E97DEC16821F43E97DEC1,
  parameter int unsigned  AM_PERIOD_NIB = 257,
  parameter int unsigned  LOCK_CNT      = 3,
  parameter int unsigned  UNLOCK_CNT    = 4,
  parameter int unsigned  MAX_NIB_ERR   = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [3:0]                       hexa_input,
  input  logic                             hexa_valid,
  output logic                             am_lock,
  output logic                             am_found,
  output logic                             lock_loss,
  output logic [1:0]                       lock_state,
  output logic [$clog2(AM_PERIOD_NIB)-1:0] nib_pos
);

  localparam int unsigned NIBS = 30;
  localparam int unsigned PW   = $clog2(AM_PERIOD_NIB);
  localparam int unsigned GW   = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW   = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned FW   = $clog2(NIBS + 1);

  localparam logic [PW-1:0] POS_LAST  = PW'(AM_PERIOD_NIB - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(NIBS);
  localparam logic [FW-1:0] FILL_LAST = FW'(NIBS - 1);

`ifdef AM_ERR_TOL_EN
  localparam int unsigned ERR_LIMIT = MAX_NIB_ERR;
`else
  // exact match only; the tolerance parameter has no effect in this build
  localparam int unsigned ERR_LIMIT = 0 * MAX_NIB_ERR;
`endif

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t          state_q, state_d;
  // the oldest nibble falls out on the shift, so only 116 bits need storage
  logic [115:0]    win_q, win_d;
  logic [119:0]    win_shift;
  logic [PW-1:0]   pos_q, pos_d, pos_inc;
  logic [GW-1:0]   good_q, good_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            found_q, found_d;
  logic            loss_q, loss_d;
  logic            pat_hit;
  logic            match;
  logic            at_exp;
  int unsigned     nib_err;

  assign win_shift = {win_q, hexa_input};

  always_comb begin
    nib_err = 0;
    for (int unsigned i = 0; i < NIBS; i++) begin
      if (win_shift[i*4 +: 4] != AM_PATTERN[i*4 +: 4]) nib_err = nib_err + 1;
    end
    pat_hit = (nib_err <= ERR_LIMIT);
  end

  // the nibble being accepted is at least the 30th since reset
  assign match   = pat_hit && (fill_q >= FILL_LAST);
  assign at_exp  = (pos_q == POS_LAST);
  assign pos_inc = at_exp ? '0 : pos_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      win_q   <= '0;
      pos_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      fill_q  <= '0;
      found_q <= 1'b0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pos_q   <= pos_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      fill_q  <= fill_d;
      found_q <= found_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    pos_d   = pos_q;
    good_d  = good_q;
    bad_d   = bad_q;
    fill_d  = fill_q;
    found_d = 1'b0;
    loss_d  = 1'b0;

    if (hexa_valid) begin
      win_d = win_shift[115:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;

      unique case (state_q)
        HUNT: begin
          pos_d = '0;
          if (match) begin
            good_d  = GW'(1);
            bad_d   = '0;
            state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          pos_d = pos_inc;
          if (at_exp) begin
            if (match) begin
              found_d = 1'b1;
              good_d  = good_q + 1'b1;
              if (good_q >= GOOD_LAST) begin
                state_d = LOCKED;
                bad_d   = '0;
              end
            end else begin
              state_d = HUNT;
              good_d  = '0;
              pos_d   = '0;
            end
          end
        end
        LOCKED: begin
          pos_d = pos_inc;
          if (at_exp) begin
            if (match) begin
              found_d = 1'b1;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 1'b1;
              if (bad_q >= BAD_LAST) begin
                state_d = HUNT;
                loss_d  = 1'b1;
                good_d  = '0;
                pos_d   = '0;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
        end
      endcase
    end
  end

  assign am_lock    = (state_q == LOCKED);
  assign am_found   = found_q;
  assign lock_loss  = loss_q;
  assign lock_state = state_q;
  assign nib_pos    = pos_q;

endmodule

// File: tb/tb_am_lock_detector.sv
// Directed bench for am_lock_detector: a nibble-history reference model checked every
// cycle, plus hand-computed literal expectations at the key stream events.
module tb_am_lock_detector;

  localparam logic [119:0] PAT_C  = 120'hC16821F43E97DEC16821F43E97DEC1;
  localparam int           PERIOD = 257;
  localparam int           LOCK   = 3;
  localparam int           UNLOCK = 4;
  localparam int           MAXERR = 1;
`ifdef AM_ERR_TOL_EN
  localparam int TOL = MAXERR;
`else
  localparam int TOL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hexa_valid;
  logic [3:0] hexa_input;
  logic       am_lock, am_found, lock_loss;
  logic [1:0] lock_state;
  logic [8:0] nib_pos;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  logic [119:0] pat;

  // reference model: last 30 accepted nibbles plus spec-level bookkeeping
  logic [3:0] hist[$];
  int m_mode  = 0;  // 0 hunt, 1 verify, 2 locked
  int m_since = 0;  // nibbles since the last reference marker
  int m_good  = 0;
  int m_bad   = 0;
  bit m_found = 1'b0;
  bit m_loss  = 1'b0;

  always #5 clk = ~clk;

  am_lock_detector #(
    .AM_PATTERN   (PAT_C),
    .AM_PERIOD_NIB(PERIOD),
    .LOCK_CNT     (LOCK),
    .UNLOCK_CNT   (UNLOCK),
    .MAX_NIB_ERR  (MAXERR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hexa_input(hexa_input),
    .hexa_valid(hexa_valid),
    .am_lock   (am_lock),
    .am_found  (am_found),
    .lock_loss (lock_loss),
    .lock_state(lock_state),
    .nib_pos   (nib_pos)
  );

  function automatic bit model_hit();
    int diff;
    diff = 0;
    if (hist.size() < 30) return 1'b0;
    for (int j = 0; j < 30; j++)
      if (hist[j] != pat[119-4*j -: 4]) diff++;
    return diff <= TOL;
  endfunction

  always @(posedge clk) begin
    m_found = 1'b0;
    m_loss  = 1'b0;
    if (!rst_n) begin
      hist.delete();
      m_mode = 0; m_since = 0; m_good = 0; m_bad = 0;
    end else if (hexa_valid) begin
      bit hit;
      hist.push_back(hexa_input);
      if (hist.size() > 30) void'(hist.pop_front());
      hit = model_hit();
      if (m_mode == 0) begin
        if (hit) begin
          m_since = 0; m_good = 1; m_bad = 0;
          m_mode = (LOCK == 1) ? 2 : 1;
        end
      end else begin
        m_since++;
        if (m_since == PERIOD) begin
          m_since = 0;
          if (hit) begin
            m_found = 1'b1;
            if (m_mode == 1) begin
              m_good++;
              if (m_good >= LOCK) begin m_mode = 2; m_bad = 0; end
            end else m_bad = 0;
          end else if (m_mode == 1) begin
            m_mode = 0; m_good = 0;
          end else begin
            m_bad++;
            if (m_bad >= UNLOCK) begin m_mode = 0; m_loss = 1'b1; end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      tests++;
      if (am_lock !== (m_mode == 2) || lock_state !== 2'(m_mode) || am_found !== m_found ||
          lock_loss !== m_loss || nib_pos !== 9'(m_since)) begin
        fails++;
        $display("FAIL model t=%0t got lock=%0b st=%0d found=%0b loss=%0b pos=%0d want lock=%0b st=%0d found=%0b loss=%0b pos=%0d",
                 $time, am_lock, lock_state, am_found, lock_loss, nib_pos,
                 (m_mode == 2), m_mode, m_found, m_loss, m_since);
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic nib(input logic [3:0] v);
    @(negedge clk); #1;
    hexa_valid = 1'b1;
    hexa_input = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      hexa_valid = 1'b0;
      hexa_input = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic filler(input int n);
    repeat (n) nib(4'($urandom_range(0, 15)));
  endtask

  // sends marker nibbles lo..hi, inverting nibbles 0..nerr-1
  task automatic marker(input int nerr, input int lo, input int hi);
    for (int j = lo; j <= hi; j++) begin
      logic [3:0] v;
      v = pat[119-4*j -: 4];
      if (j < nerr) v = ~v;
      nib(v);
    end
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    hexa_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    pat = PAT_C;
    rst_n = 1'b0;
    hexa_valid = 1'b0;
    hexa_input = 4'h0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;
    lit("reset lock", am_lock, 0);
    lit("reset state", lock_state, 0);
    lit("reset pos", nib_pos, 0);
    lit("reset found", am_found, 0);

    // 1: three clean markers -> lock
    marker(0, 0, 29); settle();
    lit("t1 verify", lock_state, 1);
    lit("t1 pos0", nib_pos, 0);
    lit("t1 nofound", am_found, 0);
    filler(227); marker(0, 0, 29); settle();
    lit("t1 found2", am_found, 1);
    lit("t1 still verify", lock_state, 1);
    filler(227); marker(0, 0, 29); settle();
    lit("t1 locked", lock_state, 2);
    lit("t1 am_lock", am_lock, 1);
    lit("t1 found3", am_found, 1);
    lit("t1 model mode", m_mode, 2);

    // 2: three misses then a good marker keep lock; four misses lose it
    for (int k = 1; k <= 3; k++) begin
      filler(227); marker(TOL + 1, 0, 29); settle();
      lit("t2 hold lock", am_lock, 1);
      lit("t2 miss nofound", am_found, 0);
      lit("t2 model bad", m_bad, k);
    end
    filler(227); marker(0, 0, 29); settle();
    lit("t2 recover found", am_found, 1);
    lit("t2 model bad0", m_bad, 0);
    for (int k = 1; k <= 4; k++) begin
      filler(227); marker(TOL + 1, 0, 29); settle();
      lit("t2 bad count", m_bad, k);
      lit("t2 loss pulse", lock_loss, (k == 4) ? 1 : 0);
      lit("t2 state", lock_state, (k == 4) ? 0 : 2);
    end
    filler(1); settle();
    lit("t2 loss cleared", lock_loss, 0);
    lit("t2 unlocked", am_lock, 0);
    filler(226);

    // re-acquire lock for the hold test
    marker(0, 0, 29); filler(227);
    marker(0, 0, 29); filler(227);
    marker(0, 0, 29); settle();
    lit("t3 relocked", lock_state, 2);

    // 3: valid gap mid-block freezes position
    filler(100); settle();
    lit("t3 pos100", nib_pos, 100);
    idle(50); settle();
    lit("t3 pos frozen", nib_pos, 100);
    lit("t3 lock held", am_lock, 1);
    filler(127); marker(0, 0, 28); settle();
    lit("t3 pos256", nib_pos, 256);
    marker(0, 29, 29); settle();
    lit("t3 found", am_found, 1);
    lit("t3 pos wrap", nib_pos, 0);
    lit("t3 still locked", lock_state, 2);

    // 5: reset while locked; partial marker afterwards must not match
    filler(10); marker(0, 0, 0);
    @(negedge clk); #1;
    hexa_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    lit("t5 async lock", am_lock, 0);
    lit("t5 async state", lock_state, 0);
    lit("t5 async pos", nib_pos, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    marker(0, 1, 29); settle();
    lit("t5 no early match", lock_state, 0);
    filler(227);

    // 4: in VERIFY the next marker arrives one nibble early
    marker(0, 0, 29); settle();
    lit("t4 verify", lock_state, 1);
    filler(226); marker(0, 0, 29); settle();
    lit("t4 early ignored", lock_state, 1);
    lit("t4 early nofound", am_found, 0);
    filler(1); settle();
    lit("t4 back to hunt", lock_state, 0);
    filler(226); marker(0, 0, 29); settle();
    lit("t4 rehunt", lock_state, 1);

    // 6: corrupted nibbles versus error tolerance
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      marker(1, 0, 29); settle();
      if (k == 3) lit("t6 one error", lock_state, (TOL > 0) ? 2 : 0);
      filler(227);
    end
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      marker(2, 0, 29); settle();
      if (k == 3) lit("t6 two errors", lock_state, 0);
      filler(227);
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
